fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined CPU. It owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and presents the fetched opcode, its PC and PC+4 to the decode stage. It honours decode stalls through a one-entry hold buffer and branch/jump redirects from EXE, including squashing a fetch that is still in flight.

---
 rtl/fetch_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus the IF/ID pipeline register.
//
// Owns the PC and keeps at most one instruction-memory request in flight
// over a valid/ready handshake. Presents the fetched word, its PC and PC+4
// to decode. Decode back-pressure is absorbed by a one-entry hold buffer.
// EXE redirects flush IF/ID and squash any fetch still in flight.
//
// Ports:
//   CLK, Reset                   clock, asynchronous active-low reset
//   imem_req_valid/addr/ready    fetch request handshake (addr = PC)
//   imem_rsp_valid/data          returned instruction word
//   stall_ID                     decode cannot accept; IF/ID holds
//   redirect_valid/addr          taken branch/jump target (bits [1:0] ignored)
//   valid_ID, entireOpCode_ID,
//   pc_ID, newAddress_next_ID    IF/ID register contents
module fetch_stage #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               CLK,
    input  logic               Reset,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               stall_ID,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               valid_ID,
    output logic [INSTR_W-1:0] entireOpCode_ID,
    output logic [ADDR_W-1:0]  pc_ID,
    output logic [ADDR_W-1:0]  newAddress_next_ID
);

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

    // REQ: issue fetch, WAIT: live fetch outstanding,
    // DROP: squashed fetch outstanding, HOLD: word parked in hold buffer
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetchState_e;

    fetchState_e        state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [INSTR_W-1:0] holdData_r;
    logic [ADDR_W-1:0]  holdPc_r;
    logic               validId_r;
    logic [INSTR_W-1:0] opCodeId_r;
    logic [ADDR_W-1:0]  pcId_r;
    logic [ADDR_W-1:0]  nextId_r;

    logic [ADDR_W-1:0]  pcPlus4_s;
    logic [ADDR_W-1:0]  redirTarget_s;
    logic               reqValid_s;
    logic               loadEn_s;
    logic [INSTR_W-1:0] loadData_s;
    logic [ADDR_W-1:0]  loadPc_s;

    // PC increment wraps naturally modulo 2^ADDR_W
    assign pcPlus4_s     = pc_r + PC_STEP;
    assign redirTarget_s = {redirect_addr[ADDR_W-1:2], 2'b00};

    // The request line is gated by Reset so it drops the instant reset asserts
    assign imem_req_valid     = reqValid_s & Reset;
    assign imem_req_addr      = pc_r;
    assign valid_ID           = validId_r;
    assign entireOpCode_ID    = opCodeId_r;
    assign pc_ID              = pcId_r;
    assign newAddress_next_ID = nextId_r;

    // Request qualification and selection of the word that enters IF/ID this cycle
    always_comb begin
        reqValid_s = (state_r == ST_REQ) && !redirect_valid;
        loadEn_s   = 1'b0;
        loadData_s = imem_rsp_data;
        loadPc_s   = pc_r;
        if (!redirect_valid && !stall_ID) begin
            if ((state_r == ST_WAIT) && imem_rsp_valid) begin
                loadEn_s = 1'b1;
            end else if (state_r == ST_HOLD) begin
                loadEn_s   = 1'b1;
                loadData_s = holdData_r;
                loadPc_s   = holdPc_r;
            end else begin
                loadEn_s = 1'b0;
            end
        end else begin
            loadEn_s = 1'b0;
        end
    end

    // Fetch FSM, PC, hold buffer and IF/ID register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r    <= ST_REQ;
            pc_r       <= RESET_PC;
            holdData_r <= {INSTR_W{1'b0}};
            holdPc_r   <= {ADDR_W{1'b0}};
            validId_r  <= 1'b0;
            opCodeId_r <= {INSTR_W{1'b0}};
            pcId_r     <= {ADDR_W{1'b0}};
            nextId_r   <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc_r <= redirTarget_s;
                    end else if (imem_req_ready) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        // A word arriving with the redirect is simply dropped
                        pc_r    <= redirTarget_s;
                        state_r <= imem_rsp_valid ? ST_REQ : ST_DROP;
                    end else if (imem_rsp_valid) begin
                        pc_r <= pcPlus4_s;
                        if (stall_ID) begin
                            holdData_r <= imem_rsp_data;
                            holdPc_r   <= pc_r;
                            state_r    <= ST_HOLD;
                        end else begin
                            state_r <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (redirect_valid) begin
                        pc_r <= redirTarget_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (imem_rsp_valid) begin
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        holdData_r <= {INSTR_W{1'b0}};
                        holdPc_r   <= {ADDR_W{1'b0}};
                        pc_r       <= redirTarget_s;
                        state_r    <= ST_REQ;
                    end else if (!stall_ID) begin
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_REQ;
                end
            endcase

            // Flush wins over stall; fields only change when a word is loaded
            if (redirect_valid) begin
                validId_r <= 1'b0;
            end else if (stall_ID) begin
                validId_r <= validId_r;
            end else begin
                validId_r <= loadEn_s;
                if (loadEn_s) begin
                    opCodeId_r <= loadData_s;
                    pcId_r     <= loadPc_s;
                    nextId_r   <= loadPc_s + PC_STEP;
                end else begin
                    opCodeId_r <= opCodeId_r;
                end
            end
        end
    end

endmodule
